// File: rtl/instr_loader.sv
// Loads 9-bit instructions into instruction memory from a byte stream:
// a length byte, then a low/high byte pair per instruction, written from address 0 upward.
module instr_loader #(
    parameter int unsigned NUM_INSTR = 256
) (
    input  logic       CLK,
    input  logic       init,
    input  logic       start,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [8:0] wr_data,
    output logic [8:0] count,
    output logic       done,
    output logic       error
);

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StLo,
        StHi,
        StWrite,
        StDone,
        StErr
    } state_t;

    localparam logic [8:0] MaxLen = 9'(NUM_INSTR);

    state_t      r_state;
    logic [7:0]  r_len;
    logic [7:0]  r_lo;
    logic [7:0]  r_addr;
    logic        r_wr_en;
    logic [7:0]  r_wr_addr;
    logic [8:0]  r_wr_data;
    logic [8:0]  r_count;
    logic        r_done;
    logic        r_error;
    logic        w_xfer;

    always_comb begin
        in_ready = (r_state == StLen) || (r_state == StLo) || (r_state == StHi);
    end

    assign w_xfer  = in_valid & in_ready;
    assign wr_en   = r_wr_en;
    assign wr_addr = r_wr_addr;
    assign wr_data = r_wr_data;
    assign count   = r_count;
    assign done    = r_done;
    assign error   = r_error;

    always_ff @(posedge CLK) begin
        if (init) begin
            r_state   <= StIdle;
            r_len     <= 8'd0;
            r_lo      <= 8'd0;
            r_addr    <= 8'd0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 8'd0;
            r_wr_data <= 9'd0;
            r_count   <= 9'd0;
            r_done    <= 1'b0;
            r_error   <= 1'b0;
        end else begin
            r_wr_en <= 1'b0;
            unique case (r_state)
                StIdle, StDone, StErr: begin
                    if (start) begin
                        r_state <= StLen;
                        r_count <= 9'd0;
                        r_addr  <= 8'd0;
                        r_done  <= 1'b0;
                        r_error <= 1'b0;
                    end
                end
                StLen: begin
                    if (w_xfer) begin
                        r_len <= in_data;
                        if (in_data == 8'd0) begin
                            r_state <= StDone;
                            r_done  <= 1'b1;
                        end else if ({1'b0, in_data} > MaxLen) begin
                            r_state <= StErr;
                            r_error <= 1'b1;
                        end else begin
                            r_state <= StLo;
                        end
                    end
                end
                StLo: begin
                    if (w_xfer) begin
                        r_lo    <= in_data;
                        r_state <= StHi;
                    end
                end
                StHi: begin
                    if (w_xfer) begin
                        // Only bit 0 of the high byte is part of the word; anything else is malformed
                        if (in_data[7:1] != 7'd0) begin
                            r_state <= StErr;
                            r_error <= 1'b1;
                        end else begin
                            r_wr_data <= {in_data[0], r_lo};
                            r_wr_addr <= r_addr;
                            r_wr_en   <= 1'b1;
                            r_state   <= StWrite;
                        end
                    end
                end
                StWrite: begin
                    r_addr  <= r_addr + 8'd1;
                    r_count <= r_count + 9'd1;
                    if (r_count + 9'd1 == {1'b0, r_len}) begin
                        r_state <= StDone;
                        r_done  <= 1'b1;
                    end else begin
                        r_state <= StLo;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: table of load programs plus hand-written
// sequences for reset, write latency and reset-during-write.
module tb_instr_loader;

    localparam int unsigned NI = 16;

    logic       CLK = 1'b0;
    logic       init;
    logic       start;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_ready;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [8:0] wr_data;
    logic [8:0] count;
    logic       done;
    logic       error;

    always #5 CLK = ~CLK;

    instr_loader #(.NUM_INSTR(NI)) dut (
        .CLK     (CLK),
        .init    (init),
        .start   (start),
        .in_valid(in_valid),
        .in_data (in_data),
        .in_ready(in_ready),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .count   (count),
        .done    (done),
        .error   (error)
    );

    int checks = 0;
    int errors = 0;
    logic [16:0] exp_q[$];  // {addr, data}

    typedef struct packed {
        logic [7:0]       len;
        logic [4:0]       npairs;
        logic [4:0]       bad;
        logic [2:0]       gap;
        logic [15:0][7:0] lo;
        logic [15:0]      hib;
        logic             exp_done;
        logic             exp_err;
        logic [8:0]       exp_cnt;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge CLK) begin
        if (wr_en === 1'b1) begin
            logic [16:0] e;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr %0h data %0h expected no write",
                         wr_addr, wr_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", {24'd0, wr_addr}, {24'd0, e[16:9]});
                chk("wr_data", {23'd0, wr_data}, {23'd0, e[8:0]});
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        in_valid = 1'b0;
        repeat (gap) begin
            in_data = 8'($urandom);
            tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        for (int k = 0; k < 50; k++) begin
            if (in_ready) begin
                tick();
                in_valid = 1'b0;
                return;
            end
            tick();
        end
        chk("xfer_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    function automatic vec_t mk(input logic [7:0] len, input int np, input int bad,
                                input int gap, input logic d, input logic e, input int cnt);
        vec_t v;
        v          = '0;
        v.len      = len;
        v.npairs   = 5'(np);
        v.bad      = 5'(bad);
        v.gap      = 3'(gap);
        v.exp_done = d;
        v.exp_err  = e;
        v.exp_cnt  = 9'(cnt);
        return v;
    endfunction

    initial begin
        logic [7:0] addr;
        init     = 1'b1;
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h05;

        // Reset with start and in_valid asserted: init wins
        tick();
        tick();
        chk("rst_in_ready", {31'd0, in_ready}, 0);
        chk("rst_wr_en", {31'd0, wr_en}, 0);
        chk("rst_wr_addr", {24'd0, wr_addr}, 0);
        chk("rst_wr_data", {23'd0, wr_data}, 0);
        chk("rst_count", {23'd0, count}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_error", {31'd0, error}, 0);
        init  = 1'b0;
        start = 1'b0;
        tick();
        chk("idle_no_ready", {31'd0, in_ready}, 0);
        in_valid = 1'b0;
        pulse_start();
        chk("len_ready", {31'd0, in_ready}, 1);
        chk("len_count", {23'd0, count}, 0);
        tick();
        chk("len_stall_ready", {31'd0, in_ready}, 1);
        init = 1'b1;
        tick();
        init = 1'b0;

        tbl[0] = mk(8'd3, 3, 31, 0, 1'b1, 1'b0, 3);
        tbl[0].lo[0] = 8'h34; tbl[0].hib[0] = 1'b1;
        tbl[0].lo[1] = 8'hFF; tbl[0].hib[1] = 1'b0;
        tbl[0].lo[2] = 8'h00; tbl[0].hib[2] = 1'b1;
        tbl[1] = tbl[0];
        tbl[1].gap = 3'd4;
        tbl[2] = mk(8'd2, 2, 1, 0, 1'b0, 1'b1, 1);
        tbl[2].lo[0] = 8'h7E; tbl[2].hib[0] = 1'b0;
        tbl[2].lo[1] = 8'h11;
        tbl[3] = mk(8'd0, 0, 31, 0, 1'b1, 1'b0, 0);
        tbl[4] = mk(8'h11, 0, 31, 0, 1'b0, 1'b1, 0);
        tbl[5] = mk(8'h10, 16, 31, 0, 1'b1, 1'b0, 16);
        for (int j = 0; j < 16; j++) begin
            tbl[5].lo[j]  = 8'(j * 17 + 3);
            tbl[5].hib[j] = j[0];
        end
        tbl[6] = mk(8'd1, 1, 31, 1, 1'b1, 1'b0, 1);
        tbl[6].lo[0] = 8'hA5; tbl[6].hib[0] = 1'b1;

        foreach (tbl[t]) begin
            pulse_start();
            chk("tbl_len_ready", {31'd0, in_ready}, 1);
            chk("tbl_start_count", {23'd0, count}, 0);
            chk("tbl_start_flags", {30'd0, done, error}, 0);
            addr = 8'd0;
            send_byte(tbl[t].len, int'(tbl[t].gap));
            for (int i = 0; i < int'(tbl[t].npairs); i++) begin
                send_byte(tbl[t].lo[i], int'(tbl[t].gap));
                if (i == int'(tbl[t].bad)) begin
                    send_byte(8'h02, int'(tbl[t].gap));
                end else begin
                    exp_q.push_back({addr, tbl[t].hib[i], tbl[t].lo[i]});
                    addr = addr + 8'd1;
                    send_byte({7'd0, tbl[t].hib[i]}, int'(tbl[t].gap));
                end
            end
            tick();
            tick();
            chk($sformatf("tbl%0d_done", t), {31'd0, done}, {31'd0, tbl[t].exp_done});
            chk($sformatf("tbl%0d_error", t), {31'd0, error}, {31'd0, tbl[t].exp_err});
            chk($sformatf("tbl%0d_count", t), {23'd0, count}, {23'd0, tbl[t].exp_cnt});
            chk($sformatf("tbl%0d_ready", t), {31'd0, in_ready}, 0);
            chk($sformatf("tbl%0d_pending", t), exp_q.size(), 0);
        end

        // Write latency: wr_en in the cycle after the HI transfer, LO ready the cycle after
        pulse_start();
        send_byte(8'd2, 0);
        send_byte(8'h12, 0);
        exp_q.push_back({8'd0, 9'h012});
        send_byte(8'h00, 0);
        chk("lat_wr_en", {31'd0, wr_en}, 1);
        chk("lat_wr_ready", {31'd0, in_ready}, 0);
        chk("lat_wr_count", {23'd0, count}, 0);
        tick();
        chk("lat_lo_wr_en", {31'd0, wr_en}, 0);
        chk("lat_lo_ready", {31'd0, in_ready}, 1);
        chk("lat_lo_count", {23'd0, count}, 1);
        send_byte(8'h9A, 0);
        exp_q.push_back({8'd1, 9'h19A});
        send_byte(8'h01, 0);
        chk("last_wr_en", {31'd0, wr_en}, 1);
        chk("last_not_done", {31'd0, done}, 0);
        tick();
        chk("last_done", {31'd0, done}, 1);
        chk("last_wr_en_low", {31'd0, wr_en}, 0);
        chk("last_count", {23'd0, count}, 2);
        chk("last_pending", exp_q.size(), 0);

        // init during WRITE: load aborts, next load restarts at address 0
        pulse_start();
        send_byte(8'd3, 0);
        send_byte(8'h55, 0);
        exp_q.push_back({8'd0, 9'h155});
        send_byte(8'h01, 0);
        init = 1'b1;
        tick();
        init = 1'b0;
        chk("abort_wr_en", {31'd0, wr_en}, 0);
        chk("abort_count", {23'd0, count}, 0);
        chk("abort_ready", {31'd0, in_ready}, 0);
        chk("abort_flags", {30'd0, done, error}, 0);
        tick();
        chk("abort_idle_wr_en", {31'd0, wr_en}, 0);
        pulse_start();
        send_byte(8'd1, 0);
        send_byte(8'h66, 0);
        exp_q.push_back({8'd0, 9'h066});
        send_byte(8'h00, 0);
        tick();
        chk("restart_done", {31'd0, done}, 1);
        chk("restart_count", {23'd0, count}, 1);
        tick();
        chk("restart_pending", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_loader.md
# instr_loader

Writes 9-bit instructions into the core's instruction memory from a byte-wide stream, filling the memory that the fetch stage reads through its 8-bit program counter. Each program arrives as a length byte followed by two bytes per instruction. Instructions are written to consecutive addresses starting at 0. The loader raises `done` when the program is complete, so the core can be released from `init`, and flags malformed streams through `error`.

## Interface
Parameters:
- NUM_INSTR, 256, instruction memory depth; legal lengths are 0..NUM_INSTR, max 256.

Ports:
- CLK  input  1  clock; all state updates on posedge.
- init  input  1  reset, synchronous, active-high.
- start  input  1  one-cycle pulse; begins a load; honoured only in IDLE, DONE, ERR.
- in_valid  input  1  source has a byte on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction memory write strobe, one cycle per instruction.
- wr_addr  output  8  write address.
- wr_data  output  9  instruction word.
- count  output  9  instructions written in the current load.
- done  output  1  load complete; held until init or start.
- error  output  1  load aborted; held until init or start.

## Operation
- Handshake: a byte transfers on a posedge where in_valid & in_ready. in_ready is high only in LEN, LO and HI; it is combinational from state.
- States:
  - IDLE: on start, go to LEN; clear count, done, error and the address counter.
  - LEN: on transfer, latch len = in_data.
    - len = 0: go to DONE.
    - len > NUM_INSTR: go to ERR.
    - otherwise: go to LO.
  - LO: on transfer, latch lo = in_data; go to HI.
  - HI: on transfer:
    - in_data[7:1] != 0: go to ERR; no write occurs.
    - otherwise: wr_data = {in_data[0], lo}; go to WRITE.
  - WRITE: assert wr_en for exactly one cycle with wr_addr = current address; address and count increment by 1 at the end of the cycle.
    - count+1 == len: go to DONE.
    - otherwise: go to LO.
  - DONE: done = 1; in_ready = 0; on start, same action as IDLE.
  - ERR: error = 1; in_ready = 0; count keeps the number of instructions already written; on start, same action as IDLE.
- start in LEN/LO/HI/WRITE is ignored.
- Width rules:
  - len is 8 bits, so the maximum expressible length is 255.
  - NUM_INSTR = 256 therefore never triggers the len > NUM_INSTR check.
  - The address counter is 8 bits and cannot wrap within a legal load, because the last address is len-1 ≤ 254.
  - count is 9 bits.
- wr_addr and wr_data hold their last values outside WRITE; memory must ignore them while wr_en = 0.

## Timing
- Reset values (the cycle after init is sampled high): state IDLE, in_ready 0, wr_en 0, wr_addr 0, wr_data 0, count 0, done 0, error 0.
- init has priority over start and over any transfer in the same cycle.
- init mid-load aborts immediately. Words already written stay in memory; no further wr_en occurs.
- Latency:
  - HI transfer at edge n → wr_en high during cycle n+1 → in_ready high again in cycle n+2 (LO).
  - Sustained throughput is one instruction per 3 cycles.
- Last write: the final WRITE cycle is followed by done = 1 from the next cycle.
- len = 0: done = 1 one cycle after the length transfer; wr_en never asserted.
- Back-pressure: in_valid low in LEN/LO/HI stalls with all outputs held. in_data is ignored while in_ready = 0.

## Test plan
- Reset and idle: init high 2 cycles with in_valid = 1 → all outputs 0, no transfers. Then start without in_valid → in_ready = 1 in LEN, count = 0.
- Basic load: start, bytes 0x03 | 0x34,0x01 | 0xFF,0x00 | 0x00,0x01 → writes (0,0x134), (1,0x0FF), (2,0x100), each wr_en one cycle. count = 3, done = 1 on the cycle after the third write, in_ready = 0 afterward.
- Back-pressure: same stream with in_valid deasserted for 4 cycles between each byte → identical writes and addresses, no duplicate wr_en.
- Malformed high byte: len 2, first instruction ok, second high byte 0x02 → exactly one write (addr 0). error = 1, done = 0, count = 1; a later start with len 0 → error clears, done = 1.
- Length limit: NUM_INSTR = 16, len 0x11 → error = 1 one cycle after the length transfer, no writes. len 0x10 with 16 instructions → last write at addr 15, done = 1.
- Reset mid-load: init asserted in the cycle after a HI transfer (WRITE) → wr_en = 0 that next cycle. The loader is in IDLE with count 0; start restarts from addr 0.
